// File: rtl/uart_io_16_if.sv
// uart_io_16_if: 16-bit CPU bus as seen by a memory-mapped I/O block.
//   addr : CPU address
//   din  : CPU write data
//   dout : read data returned by the peripheral (combinational from addr)
//   we   : CPU write strobe, sampled on posedge clk
// master = CPU side, slave = peripheral side.
interface uart_io_16_if;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        we;

    modport master (output addr, output din, output we, input dout);
    modport slave  (input addr, input din, input we, output dout);
endinterface

// File: rtl/uart_io_16.sv
// uart_io_16: memory-mapped 8N1 UART for the 16-bit system bus.
// Register window BASE_ADDR..BASE_ADDR+3:
//   +0 DATA   R: {8'h00, rx_byte}   W: push din[7:0] into the 4-entry TX FIFO
//   +1 STATUS R: {11'b0, tx_drop, rx_overrun, rx_valid, tx_full, tx_idle}
//   +2 ACK    W: clear rx_valid, rx_overrun, tx_drop
//   +3 reserved
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : CPU bus (addr, din, dout, we), slave side
//   rx    : serial input, idle high
//   tx    : serial output, idle high
module uart_io_16 #(
    parameter logic [15:0] BASE_ADDR    = 16'h5000,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           reset,
    uart_io_16_if.slave    bus,
    input  logic           rx,
    output logic           tx
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ---------------- address decode ----------------
    logic [15:0] offset;
    logic        in_win, wr_data, wr_ack;

    assign offset  = bus.addr - BASE_ADDR;
    assign in_win  = (offset[15:2] == 14'd0);
    assign wr_data = bus.we && in_win && (offset[1:0] == 2'd0);
    assign wr_ack  = bus.we && in_win && (offset[1:0] == 2'd2);

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       tx_full, fifo_empty, push, pop, tx_drop;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_idle;

    assign tx_full    = (count == 3'd4);
    assign fifo_empty = (count == 3'd0);
    // Full is judged before any pop this cycle, so a simultaneous pop never makes room.
    assign push       = wr_data && !tx_full;
    assign pop        = !fifo_empty &&
                        ((tx_state == ST_IDLE) ||
                         (tx_state == ST_STOP && tx_cnt == BIT_LAST));
    assign tx_idle    = fifo_empty && (tx_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.din[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_drop <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (wr_ack)                  tx_drop <= 1'b0;
            else if (wr_data && tx_full) tx_drop <= 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_state <= ST_START;
                        tx_shift <= fifo[rd_ptr];
                        tx       <= 1'b0;
                        tx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= ST_DATA;
                        tx       <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin // ST_STOP
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit: no idle gap.
                        if (pop) begin
                            tx_state <= ST_START;
                            tx_shift <= fifo[rd_ptr];
                            tx       <= 1'b0;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic          rx_meta, rx_s;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift, rx_byte;
    logic          rx_valid, rx_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_ack) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= ST_START;
                        rx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin // ST_STOP
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        // Completion overrides a same-cycle ACK; overrun uses pre-ACK rx_valid.
                        if (rx_s) begin
                            rx_byte    <= rx_shift;
                            rx_valid   <= 1'b1;
                            rx_overrun <= wr_ack ? rx_valid : (rx_overrun | rx_valid);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- read mux ----------------
    logic [15:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (in_win) begin
            case (offset[1:0])
                2'd0:    rd_word = {8'h00, rx_byte};
                2'd1:    rd_word = {11'b0, tx_drop, rx_overrun, rx_valid, tx_full, tx_idle};
                default: rd_word = '0;
            endcase
        end
    end

    assign bus.dout = rd_word;
endmodule

// File: tb/tb_uart_io_16.sv
module tb_uart_io_16;
    localparam int unsigned CPB = 8;
    localparam logic [15:0] A_DATA = 16'h5000;
    localparam logic [15:0] A_STAT = 16'h5001;
    localparam logic [15:0] A_ACK  = 16'h5002;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic tx;

    uart_io_16_if bus ();

    uart_io_16 #(.BASE_ADDR(16'h5000), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Serial line monitor: decodes 8N1 frames on tx, discarding any frame touched by reset.
    logic [7:0] mon_byte  [$];
    logic       mon_sbit  [$];
    logic       mon_stop  [$];
    int         mon_start [$];

    always begin
        int         s;
        logic       ab, sb, st;
        logic [7:0] b;
        @(negedge clk);
        if (reset === 1'b0 && tx === 1'b0) begin
            s  = cyc;
            ab = 1'b0;
            b  = '0;
            repeat (CPB / 2) begin @(negedge clk); if (reset) ab = 1'b1; end
            sb = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) begin @(negedge clk); if (reset) ab = 1'b1; end
                b[i] = tx;
            end
            repeat (CPB) begin @(negedge clk); if (reset) ab = 1'b1; end
            st = tx;
            if (!ab) begin
                mon_byte.push_back(b);
                mon_sbit.push_back(sb);
                mon_stop.push_back(st);
                mon_start.push_back(s);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        bus.addr = a;
        #1;
        v = bus.dout;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (mon_byte.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("frames_seen", mon_byte.size(), n);
    endtask

    // Polls STATUS until it reads exp; returns the cycle it was first seen.
    task automatic wait_status(input logic [15:0] exp, input int budget, output int c);
        logic [15:0] v;
        int k = 0;
        bus_read(A_STAT, v);
        while (v !== exp && k < budget) begin
            tick();
            k++;
            bus_read(A_STAT, v);
        end
        check("status_wait", v, exp);
        c = cyc;
    endtask

    // Pops n monitored frames, comparing against the expected byte list.
    task automatic check_frames(input logic [7:0] exp [$], input bit back_to_back);
        int prev;
        prev = 0;
        for (int i = 0; i < exp.size(); i++) begin
            if (mon_byte.size() > 0) begin
                int s;
                s = mon_start.pop_front();
                check("tx_start_bit", mon_sbit.pop_front(), 1'b0);
                check("tx_byte", mon_byte.pop_front(), exp[i]);
                check("tx_stop_bit", mon_stop.pop_front(), 1'b1);
                if (back_to_back && i > 0) check("tx_gap", s - prev, 10 * CPB);
                prev = s;
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  rb, tb_byte;
        logic [7:0]  exp_q [$];
        int          w, s, c;

        bus.addr = '0;
        bus.din  = '0;
        bus.we   = 1'b0;

        // Reset and readback
        reset = 1'b1;
        rx    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_tx", tx, 1'b1);
        bus_read(A_STAT, v);       check("reset_status", v, 16'h0001);
        bus_read(A_DATA, v);       check("reset_data", v, 16'h0000);
        bus_read(16'h5004, v);     check("outside_window", v, 16'h0000);
        bus_read(16'h5003, v);     check("reserved_reg", v, 16'h0000);

        // Single TX frame, length and latency
        bus_write(A_DATA, 16'h00A5);
        w = cyc;
        wait_frames(1, 200);
        if (mon_start.size() > 0) begin
            s = mon_start[0];
            check("tx_latency_le2", (s - w) <= 2, 1'b1);
            exp_q = '{8'hA5};
            check_frames(exp_q, 1'b0);
            wait_status(16'h0001, 40, c);
            check("tx_frame_len", c - s, 10 * CPB);
        end

        // FIFO full, drop, back-to-back
        bus_write(A_DATA, 16'h0011);
        bus_write(A_DATA, 16'h0022);
        bus_write(A_DATA, 16'h0033);
        bus_write(A_DATA, 16'h0044);
        bus_write(A_DATA, 16'h0055);
        bus_read(A_STAT, v);       check("fifo_full", v, 16'h0002);
        bus_write(A_DATA, 16'h0066);
        bus_read(A_STAT, v);       check("fifo_drop", v, 16'h0012);
        wait_frames(5, 700);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_frames(exp_q, 1'b1);
        wait_status(16'h0011, 40, c);
        bus_write(A_ACK, 16'hFFFF);
        bus_read(A_STAT, v);       check("drop_cleared", v, 16'h0001);

        // Random TX bytes (3 back-to-back, always fit)
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            tb_byte = 8'($urandom);
            exp_q.push_back(tb_byte);
            bus_write(A_DATA, {8'h00, tb_byte});
        end
        wait_frames(3, 500);
        check_frames(exp_q, 1'b1);
        wait_status(16'h0001, 40, c);

        // RX byte and ACK
        send_rx(8'h3C, 1'b1);
        bus_read(A_STAT, v);       check("rx_valid", v, 16'h0005);
        bus_read(A_DATA, v);       check("rx_data", v, 16'h003C);
        bus_write(A_ACK, 16'h1234);
        bus_read(A_STAT, v);       check("rx_ack", v, 16'h0001);

        // Random RX bytes
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            send_rx(rb, 1'b1);
            bus_read(A_DATA, v);   check("rx_rand_data", v, {8'h00, rb});
            bus_read(A_STAT, v);   check("rx_rand_status", v, 16'h0005);
            bus_write(A_ACK, 16'h0000);
        end

        // Overrun
        send_rx(8'h01, 1'b1);
        send_rx(8'h02, 1'b1);
        bus_read(A_DATA, v);       check("overrun_data", v, 16'h0002);
        bus_read(A_STAT, v);       check("overrun_status", v, 16'h000D);
        bus_write(A_ACK, 16'h0000);
        bus_read(A_STAT, v);       check("overrun_ack", v, 16'h0001);

        // Framing error
        send_rx(8'h7E, 1'b0);
        repeat (20) tick();
        bus_read(A_STAT, v);       check("framing_err", v, 16'h0001);
        bus_read(A_DATA, v);       check("framing_data", v, 16'h0002);

        // Glitch
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        repeat (20) tick();
        bus_read(A_STAT, v);       check("glitch", v, 16'h0001);

        // Reset mid-frame (TX and RX both in DATA)
        bus_write(A_DATA, {8'h00, 8'($urandom)});
        tick();
        tick();
        rx = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check("midreset_tx", tx, 1'b1);
        reset = 1'b0;
        rx    = 1'b1;
        bus_read(A_STAT, v);       check("midreset_status", v, 16'h0001);
        repeat (100) tick();
        check("midreset_no_frame", mon_byte.size(), 0);
        bus_read(A_STAT, v);       check("midreset_no_rx", v, 16'h0001);

        // Full frames after reset
        tb_byte = 8'($urandom);
        bus_write(A_DATA, {8'h00, tb_byte});
        wait_frames(1, 200);
        exp_q = '{tb_byte};
        check_frames(exp_q, 1'b0);
        wait_status(16'h0001, 40, c);
        rb = 8'($urandom);
        send_rx(rb, 1'b1);
        bus_read(A_DATA, v);       check("post_reset_rx", v, {8'h00, rb});
        bus_read(A_STAT, v);       check("post_reset_status", v, 16'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
